// File: rtl/lsu.sv
// Load/store unit: turns one execute-stage memory op into a single bus
// request/response transaction and returns an extended load result.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [DW-1:0]   addr_q;
  logic [BW-1:0]   be_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   load_data_q;

  logic            f3_legal;
  logic            aligned;
  logic            op_ok;
  logic            in_idle;
  logic [BW-1:0]   be_d;
  logic [DW-1:0]   wdata_d;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [DW-1:0]   load_ext;

  // Legality: stores only know SB/SH/SW; loads add the unsigned variants.
  always_comb begin
    f3_legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ~req_we;
      default:                f3_legal = 1'b0;
    endcase
  end

  always_comb begin
    aligned = 1'b0;
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign op_ok   = f3_legal & aligned;
  assign in_idle = (state_q == S_IDLE);

  // Byte enables and lane-replicated store data for the incoming op.
  always_comb begin
    be_d    = '0;
    wdata_d = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_d    = BW'(4'b0001 << addr[1:0]);
        wdata_d = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_d    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = wdata;
      end
    endcase
  end

  // Lane select plus sign/zero extension of the returned read word.
  always_comb begin
    lane_b = 8'h00;
    case (off_q)
      2'd0:    lane_b = mem_rdata[7:0];
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   load_ext = f3_q[2] ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_ext = f3_q[2] ? {16'h0000, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && op_ok) begin
            we_q    <= req_we;
            f3_q    <= funct3;
            off_q   <= addr[1:0];
            addr_q  <= {addr[31:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_gnt) state_q <= we_q ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            load_data_q <= load_ext;
            state_q     <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Reset gating keeps the combinational handshake outputs quiet while rst is high.
  assign stall     = ~rst & ((in_idle & req_valid & op_ok) |
                             (state_q == S_REQ) | (state_q == S_WAIT));
  assign fault     = ~rst & in_idle & req_valid & ~op_ok;
  assign done      = ~rst & (state_q == S_DONE);
  assign mem_req   = ~rst & (state_q == S_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign load_data = load_data_q;

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 req_valid  in  1  execute-stage memory op present (load or store).
REQ-004 req_we  in  1  1 = store, 0 = load.
REQ-005 funct3  in  3  RV32I size/sign code; load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW.
REQ-006 addr  in  32  byte address from ALU.
REQ-007 wdata  in  32  store data (rs2).
REQ-008 stall  out  1  core must hold its pipeline and request inputs while 1.
REQ-009 done  out  1  one-cycle pulse on op completion.
REQ-010 load_data  out  32  extended load result, valid while done=1 for a load.
REQ-011 fault  out  1  one-cycle pulse on misaligned address or illegal funct3.
REQ-012 mem_req  out  1  bus request.
REQ-013 mem_we  out  1  bus write enable.
REQ-014 mem_addr  out  32  word address, bits [1:0] always 0.
REQ-015 mem_be  out  4  byte-lane enables.
REQ-016 mem_wdata  out  32  lane-aligned store data.
REQ-017 mem_gnt  in  1  bus accepts request in the current cycle.
REQ-018 mem_rvalid  in  1  mem_rdata valid in the current cycle.
REQ-019 mem_rdata  in  32  read word.

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-021 Legality check (IDLE only): LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0; any other funct3 is illegal.
REQ-022 IDLE, req_valid=1, illegal or misaligned: fault=1 this cycle, stall=0, no bus activity, stay IDLE.
REQ-023 IDLE, req_valid=1, legal: stall=1 combinationally; register mem_addr={addr[31:2],2'b00}, mem_we=req_we, mem_be, mem_wdata, funct3, addr[1:0]; next state REQ.
REQ-024 mem_be: byte = 4'b0001<<addr[1:0]; half = 4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1); word = 4'b1111.
REQ-025 mem_wdata: SB = wdata[7:0] replicated ×4; SH = wdata[15:0] replicated ×2; SW = wdata.
REQ-026 REQ: mem_req=1, stall=1; mem_addr/mem_be/mem_wdata/mem_we held stable until mem_gnt=1; on gnt, store -> DONE, load -> WAIT.
REQ-027 WAIT: mem_req=0, stall=1; on mem_rvalid=1 register extended lane into load_data, -> DONE; wait unbounded otherwise.
REQ-028 Load extraction: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW raw word.
REQ-029 DONE: done=1, stall=0 for exactly one cycle, -> IDLE unconditionally; req_valid in DONE SHALL NOT start a new op.
REQ-030 Minimum latency (gnt same cycle as mem_req, rvalid next cycle): store accept->done 2 cycles, load 3 cycles.
REQ-031 Back-to-back ops: next legal req_valid accepted in the IDLE cycle following DONE.
REQ-032 mem_rvalid outside WAIT and mem_gnt outside REQ SHALL be ignored.
REQ-033 load_data SHALL hold its value until the next load completes.

Reset
REQ-034 rst=1 SHALL force IDLE immediately, including mid-REQ/WAIT; mem_req, stall, done, fault drop to 0 without waiting for clk.
REQ-035 Reset values: mem_addr=0, mem_be=0, mem_wdata=0, mem_we=0, load_data=0.
REQ-036 A mem_rvalid arriving after a mid-WAIT reset SHALL be discarded.

Verification
REQ-037 SB addr=0x1003 wdata=0x000000A5, gnt immediate -> mem_addr=0x1000, be=4'b1000, mem_wdata=0xA5A5A5A5, done 2 cycles after accept.
REQ-038 LH addr=0x2002, mem_rdata=0x80FF1234 -> load_data=0xFFFF80FF; LHU same -> 0x000080FF.
REQ-039 LW addr=0x3001 -> fault pulse, stall=0, mem_req never asserted.
REQ-040 SW with mem_gnt held low 5 cycles -> mem_req and bus fields stable 6 cycles, stall=1 throughout, single done.
REQ-041 LB issued, rst pulsed in WAIT, then stray mem_rvalid -> state IDLE, no done, load_data=0.
REQ-042 LBU addr=0x10 followed immediately by SW addr=0x20 -> two done pulses, second op accepted in IDLE after first DONE.
